// File: rtl/cnn_stream_pkg.sv
// Shared types and helpers for the CNN frame streamer: FSM states, frame size
// and the packing of a classification result into a result FIFO word.
package cnn_stream_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STREAM,
        S_WAIT_RES,
        S_WRITE_RES,
        S_DONE,
        S_ERR
    } state_t;

    function automatic int img_pixels(input int dim);
        return dim * dim;
    endfunction

    // Image index in the upper bits, digit in the low bits; the index wraps at
    // the width left over above the digit.
    function automatic logic [63:0] pack_result(
        input logic [31:0] idx,
        input logic [31:0] digit,
        input int          d_width,
        input int          bcd_bits
    );
        logic [63:0] idx_mask;
        logic [63:0] dig_mask;
        idx_mask = (64'd1 << (d_width - bcd_bits)) - 64'd1;
        dig_mask = (64'd1 << bcd_bits) - 64'd1;
        return (((64'(idx) & idx_mask) << bcd_bits) | (64'(digit) & dig_mask));
    endfunction

endpackage

// File: rtl/mod_N_counter.sv
// Modulo-N up-counter with synchronous clear; done flags the terminal count.
module mod_N_counter #(
    parameter int N      = 10,
    parameter int N_BITS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    output logic [N_BITS-1:0] count,
    output logic              done
);

    assign done = (count == N_BITS'(N - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            if (done) count <= '0;
            else      count <= count + N_BITS'(1);
        end
    end

endmodule

// File: rtl/cnn_frame_streamer.sv
// Streams one frame at a time from a FWFT source FIFO into the CNN, waits for
// the classified digit and pushes {image index, digit} into the result FIFO.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | after reset, waiting for start
// S_STREAM    | forwarding source pixels to the CNN until a frame is sent
// S_WAIT_RES  | frame sent, waiting for digit_i_valid or timeout
// S_WRITE_RES | holding the result word until the result FIFO accepts it
// S_DONE      | all NUM_IMAGES results written; start begins a new run
// S_ERR       | CNN never answered; start begins a new run
module cnn_frame_streamer
    import cnn_stream_pkg::*;
#(
    parameter int GS_BITS        = 8,
    parameter int BCD_BITS       = 4,
    parameter int D_WIDTH        = 16,
    parameter int IMG_DIM        = 30,
    parameter int NUM_IMAGES     = 1000,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                src_empty,
    input  logic [D_WIDTH-1:0]  src_dout,
    output logic                src_rd_en,
    output logic [GS_BITS-1:0]  pixel_o,
    output logic                pixel_o_valid,
    input  logic [BCD_BITS-1:0] digit_i,
    input  logic                digit_i_valid,
    input  logic                res_full,
    output logic                res_wr_en,
    output logic [D_WIDTH-1:0]  res_din,
    output logic                busy,
    output logic                done,
    output logic                timeout_err,
    output logic                err_spurious,
    output logic [31:0]         img_count
);

    localparam int IMG_PIXELS = img_pixels(IMG_DIM);

    state_t              state;
    logic [31:0]         tmo_count;
    logic [BCD_BITS-1:0] digit_q;
    logic [31:0]         pix_count;
    logic                pix_last;
    logic                xfer;
    logic                start_ok;
    logic                unused_bits;

    assign xfer     = (state == S_STREAM) && !src_empty;
    assign start_ok = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));

    assign src_rd_en     = xfer;
    assign pixel_o_valid = xfer;
    assign pixel_o       = (state == S_STREAM) ? src_dout[GS_BITS-1:0] : '0;
    assign res_wr_en     = (state == S_WRITE_RES) && !res_full;
    assign res_din       = D_WIDTH'(pack_result(img_count, 32'(digit_q), D_WIDTH, BCD_BITS));
    assign busy          = (state == S_STREAM) || (state == S_WAIT_RES) || (state == S_WRITE_RES);

    // Pixel position within the frame; only the terminal-count flag matters here.
    assign unused_bits = ^{pix_count, src_dout[D_WIDTH-1:GS_BITS]};

    mod_N_counter #(
        .N      (IMG_PIXELS),
        .N_BITS (32)
    ) u_pix_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (start_ok),
        .en    (xfer),
        .count (pix_count),
        .done  (pix_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            tmo_count    <= '0;
            img_count    <= '0;
            digit_q      <= '0;
            done         <= 1'b0;
            timeout_err  <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state        <= S_STREAM;
                        img_count    <= '0;
                        tmo_count    <= '0;
                        done         <= 1'b0;
                        timeout_err  <= 1'b0;
                        err_spurious <= 1'b0;
                    end
                end
                S_STREAM: begin
                    if (xfer && pix_last) begin
                        tmo_count <= '0;
                        state     <= S_WAIT_RES;
                    end
                end
                S_WAIT_RES: begin
                    // A digit arriving on the expiry cycle still counts.
                    if (digit_i_valid) begin
                        digit_q <= digit_i;
                        state   <= S_WRITE_RES;
                    end else if (tmo_count == 32'(TIMEOUT_CYCLES - 1)) begin
                        timeout_err <= 1'b1;
                        state       <= S_ERR;
                    end else begin
                        tmo_count <= tmo_count + 32'd1;
                    end
                end
                S_WRITE_RES: begin
                    if (!res_full) begin
                        img_count <= img_count + 32'd1;
                        if ((img_count + 32'd1) == 32'(NUM_IMAGES)) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            state <= S_STREAM;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (digit_i_valid && (state != S_WAIT_RES)) err_spurious <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cnn_frame_streamer.sv
// Self-checking bench for cnn_frame_streamer: table-driven runs, corner-case
// sequences and randomized runs checked against a simple FIFO/result model.
module tb_cnn_frame_streamer;

    localparam int GS   = 8;
    localparam int BCD  = 4;
    localparam int DW   = 16;
    localparam int DIM  = 4;
    localparam int NIMG = 2;
    localparam int TMO  = 10;
    localparam int PIX  = DIM * DIM;

    logic           clk;
    logic           rst;
    logic           start;
    logic           src_empty;
    logic [DW-1:0]  src_dout;
    logic           src_rd_en;
    logic [GS-1:0]  pixel_o;
    logic           pixel_o_valid;
    logic [BCD-1:0] digit_i;
    logic           digit_i_valid;
    logic           res_full;
    logic           res_wr_en;
    logic [DW-1:0]  res_din;
    logic           busy;
    logic           done;
    logic           timeout_err;
    logic           err_spurious;
    logic [31:0]    img_count;

    cnn_frame_streamer #(
        .GS_BITS        (GS),
        .BCD_BITS       (BCD),
        .D_WIDTH        (DW),
        .IMG_DIM        (DIM),
        .NUM_IMAGES     (NIMG),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .src_empty     (src_empty),
        .src_dout      (src_dout),
        .src_rd_en     (src_rd_en),
        .pixel_o       (pixel_o),
        .pixel_o_valid (pixel_o_valid),
        .digit_i       (digit_i),
        .digit_i_valid (digit_i_valid),
        .res_full      (res_full),
        .res_wr_en     (res_wr_en),
        .res_din       (res_din),
        .busy          (busy),
        .done          (done),
        .timeout_err   (timeout_err),
        .err_spurious  (err_spurious),
        .img_count     (img_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Source FIFO model (first-word-fall-through) and expected pixel stream.
    logic [DW-1:0] src_mem [0:1023];
    logic [GS-1:0] exp_pix [0:1023];
    logic [9:0]    wr_ptr;
    logic [9:0]    rd_ptr;
    logic          empty_force;
    logic          toggle_en;

    assign src_empty = (rd_ptr == wr_ptr) || empty_force;
    assign src_dout  = src_mem[rd_ptr];

    int total;
    int bad;
    int cyc;
    int last_xfer_cyc;
    int xfer_total;
    int wr_total;
    int pix_bad;
    int viol;
    logic [DW-1:0] last_wr;

    always @(negedge clk) begin
        if (toggle_en) empty_force = ~empty_force;
        else           empty_force = 1'b0;
    end

    always @(posedge clk) begin
        cyc++;
        if (src_rd_en) begin
            if (pixel_o !== exp_pix[rd_ptr]) pix_bad++;
            rd_ptr <= rd_ptr + 10'd1;
            xfer_total++;
            last_xfer_cyc = cyc;
        end
        if ((pixel_o_valid !== src_rd_en) || (pixel_o_valid && src_empty)) viol++;
        if (res_wr_en) begin
            if (res_full) viol++;
            wr_total++;
            last_wr = res_din;
        end
    end

    typedef struct packed {
        logic [3:0]  d0;
        logic [3:0]  d1;
        logic [7:0]  stall;
        logic        toggle;
        logic        spur;
        logic [15:0] exp0;
        logic [15:0] exp1;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference: result word is image index (mod 2^(DW-BCD)) above the digit.
    function automatic logic [15:0] model_word(input int idx, input int d);
        return 16'(((idx % (1 << (DW - BCD))) * (1 << BCD)) + d);
    endfunction

    task automatic push(input logic [DW-1:0] w);
        src_mem[wr_ptr] = w;
        exp_pix[wr_ptr] = w[GS-1:0];
        wr_ptr = wr_ptr + 10'd1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_digit(input logic [3:0] d);
        digit_i       = d;
        digit_i_valid = 1'b1;
        @(negedge clk);
        digit_i_valid = 1'b0;
    endtask

    task automatic wait_xfers(input int target);
        int n;
        n = 0;
        while (xfer_total < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("xfer_reach", 64'(xfer_total), 64'(target));
    endtask

    task automatic run_vec(input vec_t v);
        int          bx;
        int          bw;
        logic [3:0]  d;
        logic [15:0] e;
        for (int i = 0; i < 2 * PIX; i++) push(DW'($urandom));
        toggle_en = v.toggle;
        bx = xfer_total;
        bw = wr_total;
        @(negedge clk);
        pulse_start();
        chk("busy_after_start", busy, 1);
        chk("tmo_err_cleared", timeout_err, 0);
        chk("spur_cleared", err_spurious, 0);
        chk("done_cleared", done, 0);
        chk("img_count_zero", img_count, 0);
        if (!v.toggle) chk("first_pix_latency", pixel_o_valid, 1);
        for (int f = 0; f < NIMG; f++) begin
            d = (f == 0) ? v.d0 : v.d1;
            e = (f == 0) ? v.exp0 : v.exp1;
            if (v.spur && f == 0) begin
                wait_xfers(bx + 5);
                pulse_digit(4'd9);
                chk("spur_flag", err_spurious, 1);
                chk("spur_no_write", 64'(wr_total), 64'(bw));
            end
            wait_xfers(bx + PIX * (f + 1));
            repeat (3) @(negedge clk);
            chk("frame_len", 64'(xfer_total), 64'(bx + PIX * (f + 1)));
            chk("busy_wait", busy, 1);
            if (v.stall > 0 && f == 0) begin
                res_full = 1'b1;
                pulse_digit(d);
                for (int s = 0; s < int'(v.stall); s++) begin
                    chk("stall_wr_en", res_wr_en, 0);
                    @(negedge clk);
                end
                chk("stall_no_write", 64'(wr_total), 64'(bw + f));
                chk("stall_no_read", 64'(xfer_total), 64'(bx + PIX * (f + 1)));
                res_full = 1'b0;
                #1;
            end else begin
                pulse_digit(d);
            end
            chk("wr_en", res_wr_en, 1);
            chk("res_din", res_din, e);
            @(negedge clk);
            chk("wr_count", 64'(wr_total), 64'(bw + f + 1));
            chk("wr_word", last_wr, e);
        end
        toggle_en = 1'b0;
        chk("done_set", done, 1);
        chk("img_count_end", img_count, NIMG);
        chk("busy_end", busy, 0);
        chk("writes_per_run", 64'(wr_total), 64'(bw + NIMG));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   bx;
        int   bw;
        int   n;
        vec_t rv;

        total = 0; bad = 0; cyc = 0; last_xfer_cyc = 0;
        xfer_total = 0; wr_total = 0; pix_bad = 0; viol = 0; last_wr = '0;
        wr_ptr = '0; rd_ptr = '0; empty_force = 1'b0; toggle_en = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            src_mem[i] = '0;
            exp_pix[i] = '0;
        end
        rst = 1'b1; start = 1'b0; digit_i = '0; digit_i_valid = 1'b0; res_full = 1'b0;

        //        d0    d1    stall tog  spur exp0      exp1
        vecs[0] = {4'd7, 4'd3, 8'd0, 1'b0, 1'b0, 16'h0007, 16'h0013};
        vecs[1] = {4'd2, 4'd5, 8'd0, 1'b1, 1'b0, 16'h0002, 16'h0015};
        vecs[2] = {4'd4, 4'd9, 8'd5, 1'b0, 1'b0, 16'h0004, 16'h0019};
        vecs[3] = {4'd0, 4'd15, 8'd0, 1'b0, 1'b1, 16'h0000, 16'h001F};

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_rd_en", src_rd_en, 0);
        chk("rst_pix_valid", pixel_o_valid, 0);
        chk("rst_pixel", pixel_o, 0);
        chk("rst_wr_en", res_wr_en, 0);
        chk("rst_res_din", res_din, 0);
        chk("rst_done", done, 0);
        chk("rst_img_count", img_count, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) run_vec(vecs[i]);

        // CNN never answers: expect ERR after exactly TMO waiting cycles.
        push(16'h0000);
        for (int i = 1; i < PIX; i++) push(DW'($urandom));
        bx = xfer_total;
        bw = wr_total;
        pulse_start();
        wait_xfers(bx + PIX);
        n = 0;
        while (!timeout_err && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_latency", 64'(cyc - last_xfer_cyc), TMO);
        chk("timeout_busy", busy, 0);
        chk("timeout_no_write", 64'(wr_total), 64'(bw));
        chk("timeout_no_read", 64'(xfer_total), 64'(bx + PIX));
        run_vec(vecs[0]);

        // Reset in the middle of a frame; leftover source words stay queued.
        for (int i = 0; i < 2 * PIX; i++) push(DW'($urandom));
        bx = xfer_total;
        pulse_start();
        wait_xfers(bx + 5);
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_rd_en", src_rd_en, 0);
        chk("midrst_pix_valid", pixel_o_valid, 0);
        chk("midrst_pixel", pixel_o, 0);
        chk("midrst_wr_en", res_wr_en, 0);
        chk("midrst_img_count", img_count, 0);
        chk("midrst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_vec(vecs[0]);

        for (int r = 0; r < 4; r++) begin
            rv.d0     = 4'($urandom_range(0, 15));
            rv.d1     = 4'($urandom_range(0, 15));
            rv.stall  = 8'($urandom_range(0, 3));
            rv.toggle = 1'($urandom_range(0, 1));
            rv.spur   = 1'b0;
            rv.exp0   = model_word(0, int'(rv.d0));
            rv.exp1   = model_word(1, int'(rv.d1));
            run_vec(rv);
        end

        chk("pixel_order", 64'(pix_bad), 0);
        chk("handshake", 64'(viol), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
